// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor
//
// Multi-cycle subtractor computing diff = in1 - in2 - bIn. The operand is split into
// CHUNKWIDTH-bit slices; stage k resolves slice k as in1 + ~in2 + carry. The borrow is
// registered between stages, so the critical path is one CHUNKWIDTH-bit add. Each stage
// carries the operands and the finished lower diff slices alongside its valid bit.
// Results come straight from the last-stage registers.
//
// Optional feature: define PIPELINED_SUB_FLAGS_EN to generate the zero / negative /
// overflow flags. Without it those ports are tied to 0 and no flag state is built.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset; discards all in-flight bundles
//   in1       in   minuend (BITWIDTH)
//   in2       in   subtrahend (BITWIDTH)
//   bIn       in   borrow in
//   inValid   in   operand bundle valid
//   inReady   out  a bundle is accepted this cycle if inValid is also high
//   diff      out  result (BITWIDTH)
//   bOut      out  borrow out of the MSB (unsigned in1 < in2 + bIn)
//   outValid  out  diff / bOut / flags valid
//   outReady  in   consumer takes the result this cycle
//   zero      out  diff == 0
//   negative  out  diff MSB
//   overflow  out  signed overflow of the subtraction

module pipelined_subtractor #(
  parameter int unsigned BITWIDTH   = 64,
  parameter int unsigned CHUNKWIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BITWIDTH-1:0] in1,
  input  logic [BITWIDTH-1:0] in2,
  input  logic                bIn,
  input  logic                inValid,
  output logic                inReady,
  output logic [BITWIDTH-1:0] diff,
  output logic                bOut,
  output logic                outValid,
  input  logic                outReady,
  output logic                zero,
  output logic                negative,
  output logic                overflow
);

  localparam int unsigned NUMSTAGES = BITWIDTH / CHUNKWIDTH;
  localparam int unsigned LastStage = NUMSTAGES - 1;

  if ((CHUNKWIDTH == 0) || (BITWIDTH % CHUNKWIDTH != 0)) begin : g_bad_width
    $error("pipelined_subtractor: BITWIDTH must be a multiple of CHUNKWIDTH");
  end

  // Stage registers
  logic [NUMSTAGES-1:0] r_valid;
  logic [NUMSTAGES-1:0] r_borrow;
  logic [BITWIDTH-1:0]  r_a [NUMSTAGES];
  logic [BITWIDTH-1:0]  r_b [NUMSTAGES];
  logic [BITWIDTH-1:0]  r_d [NUMSTAGES];

  // Stage inputs (what each stage would load) and next-state values
  logic [BITWIDTH-1:0]  w_a_in [NUMSTAGES];
  logic [BITWIDTH-1:0]  w_b_in [NUMSTAGES];
  logic [BITWIDTH-1:0]  w_d_in [NUMSTAGES];
  logic [NUMSTAGES-1:0] w_c_in;
  logic [NUMSTAGES-1:0] w_src_valid;
  logic [CHUNKWIDTH:0]  w_sum [NUMSTAGES];
  logic [BITWIDTH-1:0]  w_d_next [NUMSTAGES];
  logic [NUMSTAGES-1:0] w_borrow_next;
  logic [NUMSTAGES-1:0] w_load;
  logic [NUMSTAGES-1:0] w_adv;

  always_comb begin : stage_inputs
    w_a_in[0]      = in1;
    w_b_in[0]      = in2;
    w_d_in[0]      = '0;
    w_c_in         = '0;
    w_src_valid    = '0;
    w_c_in[0]      = ~bIn;
    w_src_valid[0] = inValid;
    for (int k = 1; k < int'(NUMSTAGES); k++) begin
      w_a_in[k]      = r_a[k-1];
      w_b_in[k]      = r_b[k-1];
      w_d_in[k]      = r_d[k-1];
      w_c_in[k]      = ~r_borrow[k-1];
      w_src_valid[k] = r_valid[k-1];
    end
  end

  // Slice k of a - b - borrow as a + ~b + carry; borrow out is the inverted carry.
  always_comb begin : stage_arith
    w_borrow_next = '0;
    for (int k = 0; k < int'(NUMSTAGES); k++) begin
      w_sum[k] = {1'b0, w_a_in[k][k*CHUNKWIDTH +: CHUNKWIDTH]}
               + {1'b0, ~w_b_in[k][k*CHUNKWIDTH +: CHUNKWIDTH]}
               + {{CHUNKWIDTH{1'b0}}, w_c_in[k]};
      w_d_next[k] = w_d_in[k];
      w_d_next[k][k*CHUNKWIDTH +: CHUNKWIDTH] = w_sum[k][CHUNKWIDTH-1:0];
      w_borrow_next[k] = ~w_sum[k][CHUNKWIDTH];
    end
  end

  // Stall chain, resolved from the output back to the input. An empty stage always
  // loads, so bubbles never block upstream.
  always_comb begin : handshake
    w_adv  = '0;
    w_load = '0;
    w_adv[LastStage]  = r_valid[LastStage] & outReady;
    w_load[LastStage] = ~r_valid[LastStage] | w_adv[LastStage];
    for (int k = int'(NUMSTAGES) - 2; k >= 0; k--) begin
      w_adv[k]  = r_valid[k] & w_load[k+1];
      w_load[k] = ~r_valid[k] | w_adv[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= '0;
      r_borrow <= '0;
      for (int k = 0; k < int'(NUMSTAGES); k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_d[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NUMSTAGES); k++) begin
        if (w_load[k]) begin
          r_valid[k] <= w_src_valid[k];
          // Data only moves with a real bundle, so outputs stay put across bubbles.
          if (w_src_valid[k]) begin
            r_a[k]      <= w_a_in[k];
            r_b[k]      <= w_b_in[k];
            r_d[k]      <= w_d_next[k];
            r_borrow[k] <= w_borrow_next[k];
          end
        end
      end
    end
  end

  assign inReady  = w_load[0];
  assign outValid = r_valid[LastStage];
  assign diff     = r_d[LastStage];
  assign bOut     = r_borrow[LastStage];

`ifdef PIPELINED_SUB_FLAGS_EN
  logic [NUMSTAGES-1:0] r_zero;
  logic [NUMSTAGES-1:0] w_zero_in;
  logic [NUMSTAGES-1:0] w_zero_next;
  logic                 r_ovf;
  logic                 w_ovf_next;

  // Zero is an AND of per-slice zero tests accumulated down the pipe.
  always_comb begin : flag_next
    w_zero_in    = '0;
    w_zero_in[0] = 1'b1;
    for (int k = 1; k < int'(NUMSTAGES); k++) begin
      w_zero_in[k] = r_zero[k-1];
    end
    for (int k = 0; k < int'(NUMSTAGES); k++) begin
      w_zero_next[k] = w_zero_in[k] & (w_sum[k][CHUNKWIDTH-1:0] == '0);
    end
    w_ovf_next = (w_a_in[LastStage][BITWIDTH-1] ^ w_b_in[LastStage][BITWIDTH-1])
               & (w_d_next[LastStage][BITWIDTH-1] ^ w_a_in[LastStage][BITWIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero <= '0;
      r_ovf  <= 1'b0;
    end else begin
      for (int k = 0; k < int'(NUMSTAGES); k++) begin
        if (w_load[k] && w_src_valid[k]) begin
          r_zero[k] <= w_zero_next[k];
        end
      end
      if (w_load[LastStage] && w_src_valid[LastStage]) begin
        r_ovf <= w_ovf_next;
      end
    end
  end

  assign zero     = r_zero[LastStage];
  assign negative = r_d[LastStage][BITWIDTH-1];
  assign overflow = r_ovf;
`else
  assign zero     = 1'b0;
  assign negative = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench for pipelined_subtractor (64-bit, 16-bit chunks, 4 stages).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_pipelined_subtractor;

  localparam int unsigned BW  = 64;
  localparam int unsigned Lat = 4;

`ifdef PIPELINED_SUB_FLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [BW-1:0] in1;
  logic [BW-1:0] in2;
  logic          bIn;
  logic          inValid;
  logic          inReady;
  logic [BW-1:0] diff;
  logic          bOut;
  logic          outValid;
  logic          outReady;
  logic          zero;
  logic          negative;
  logic          overflow;

  pipelined_subtractor #(
    .BITWIDTH  (64),
    .CHUNKWIDTH(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in1     (in1),
    .in2     (in2),
    .bIn     (bIn),
    .inValid (inValid),
    .inReady (inReady),
    .diff    (diff),
    .bOut    (bOut),
    .outValid(outValid),
    .outReady(outReady),
    .zero    (zero),
    .negative(negative),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, outValid, 0);
    check({tag, "_in_ready"}, inReady, 1);
    check({tag, "_diff"}, diff, 0);
    check({tag, "_bout"}, bOut, 0);
    check({tag, "_zero"}, zero, 0);
    check({tag, "_negative"}, negative, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  // Present one bundle, then count falling edges until outValid appears.
  task automatic run_one(input logic [63:0] a, input logic [63:0] b, input logic bin,
                         input string tag, output int lat);
    @(negedge clk);
    in1      = a;
    in2      = b;
    bIn      = bin;
    inValid  = 1'b1;
    outReady = 1'b1;
    #1;
    check({tag, "_in_ready"}, inReady, 1);
    @(negedge clk);
    inValid = 1'b0;
    lat     = 1;
    while (!outValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] d;
    logic        bout;
    logic        z;
    logic        n;
    logic        o;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat;
    int sent;
    int pops;

    //              a                      b                      bin   diff                  bout z  n  o
    vecs[0] = '{64'd5,                 64'd3,                 1'b0, 64'd2,                 1'b0, 0, 0, 0};
    vecs[1] = '{64'd0,                 64'd1,                 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 1, 0};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'd1,               1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 0, 0, 1};
    vecs[3] = '{64'h1234,              64'h1234,              1'b0, 64'd0,                 1'b0, 1, 0, 0};
    vecs[4] = '{64'h1234,              64'h1234,              1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 1, 0};
    vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 0, 1, 1};
    vecs[6] = '{64'h0000_0001_0000_0000, 64'd1,               1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 0, 0, 0};
    vecs[7] = '{64'd10,                64'd3,                 1'b1, 64'd6,                 1'b0, 0, 0, 0};

    reset    = 1'b1;
    in1      = '0;
    in2      = '0;
    bIn      = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Single-bundle vectors
    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].bin, $sformatf("vec%0d", i), lat);
      check($sformatf("vec%0d_latency", i), lat, Lat);
      check($sformatf("vec%0d_diff", i), diff, vecs[i].d);
      check($sformatf("vec%0d_bout", i), bOut, vecs[i].bout);
      check($sformatf("vec%0d_zero", i), zero, FlagsEn ? vecs[i].z : 1'b0);
      check($sformatf("vec%0d_negative", i), negative, FlagsEn ? vecs[i].n : 1'b0);
      check($sformatf("vec%0d_overflow", i), overflow, FlagsEn ? vecs[i].o : 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d_drained", i), outValid, 0);
    end

    // Back-to-back bundles with a 6-cycle output stall starting at cycle 2
    sent = 0;
    pops = 0;
    for (int c = 0; c < 40 && pops < 8; c++) begin
      @(negedge clk);
      if (c < 16) check($sformatf("bp_out_valid_c%0d", c), outValid, (c >= 4));
      outReady = !(c >= 2 && c < 8);
      if (sent < 8) begin
        in1     = 64'(sent + 10);
        in2     = 64'(sent);
        bIn     = 1'b0;
        inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      #1;
      if (c < 8) check($sformatf("bp_in_ready_c%0d", c), inReady, !(c >= 4));
      if (inValid && inReady) sent++;
      if (outValid && outReady) begin
        check($sformatf("bp_diff%0d", pops), diff, 10);
        check($sformatf("bp_bout%0d", pops), bOut, 0);
        check($sformatf("bp_pop_cycle%0d", pops), c, 8 + pops);
        pops++;
      end
    end
    check("bp_sent", sent, 8);
    check("bp_pops", pops, 8);
    inValid = 1'b0;
    @(negedge clk);
    check("bp_drained", outValid, 0);

    // Reset with three bundles in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in1      = 64'(100 + i);
      in2      = 64'(i);
      bIn      = 1'b0;
      inValid  = 1'b1;
      outReady = 1'b1;
    end
    @(negedge clk);
    inValid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    reset = 1'b0;
    run_one(64'd7, 64'd2, 1'b0, "postrst", lat);
    check("postrst_latency", lat, Lat);
    check("postrst_diff", diff, 5);
    check("postrst_bout", bOut, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("postrst_no_stale%0d", i), outValid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
